// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The arbiter uses the slave modport; the environment side uses master.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_gnt;
   logic              a_rvalid;
   logic [DATA_W-1:0] a_rdata;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_gnt;
   logic              b_rvalid;
   logic [DATA_W-1:0] b_rdata;

   logic [ADDR_W-1:0] mem_access_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_write_en;
   logic              mem_read;
   logic [DATA_W-1:0] mem_read_data;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      input  b_req, b_we, b_addr, b_wdata,
      input  mem_read_data,
      output a_gnt, a_rvalid, a_rdata,
      output b_gnt, b_rvalid, b_rdata,
      output mem_access_addr, mem_write_data, mem_write_en, mem_read
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      output b_req, b_we, b_addr, b_wdata,
      output mem_read_data,
      input  a_gnt, a_rvalid, a_rdata,
      input  b_gnt, b_rvalid, b_rdata,
      input  mem_access_addr, mem_write_data, mem_write_en, mem_read
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port A-priority arbiter for the single-ported data memory, with a
// starvation bound for port B and registered one-cycle read return.
module dmem_arbiter #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   dmem_arbiter_if.slave   bus
);
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              a_rvalid_q, a_rvalid_d;
   logic              b_rvalid_q, b_rvalid_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
   logic              b_force_c;
   logic              a_gnt_c;
   logic              b_gnt_c;

   // Grant select; held off while in reset so outputs track the reset state.
   always_comb begin
      b_force_c = (wait_cnt_q == WAIT_LIM);
      a_gnt_c   = rst_n && bus.a_req && !(bus.b_req && b_force_c);
      b_gnt_c   = rst_n && bus.b_req && !(bus.a_req && !b_force_c);
   end

   // Memory pin mux; everything idles at zero when nobody is granted.
   always_comb begin
      bus.mem_access_addr = '0;
      bus.mem_write_data  = '0;
      bus.mem_write_en    = 1'b0;
      bus.mem_read        = 1'b0;
      if (a_gnt_c) begin
         bus.mem_access_addr = bus.a_addr;
         bus.mem_write_data  = bus.a_wdata;
         bus.mem_write_en    = bus.a_we;
         bus.mem_read        = !bus.a_we;
      end else if (b_gnt_c) begin
         bus.mem_access_addr = bus.b_addr;
         bus.mem_write_data  = bus.b_wdata;
         bus.mem_write_en    = bus.b_we;
         bus.mem_read        = !bus.b_we;
      end
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      a_rvalid_d = a_gnt_c && !bus.a_we;
      b_rvalid_d = b_gnt_c && !bus.b_we;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;

      if (!bus.b_req || b_gnt_c) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != WAIT_LIM) begin
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end

      if (a_rvalid_d) a_rdata_d = bus.mem_read_data;
      if (b_rvalid_d) b_rdata_d = bus.mem_read_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
      end
   end

   assign bus.a_gnt    = a_gnt_c;
   assign bus.b_gnt    = b_gnt_c;
   assign bus.a_rvalid = a_rvalid_q;
   assign bus.b_rvalid = b_rvalid_q;
   assign bus.a_rdata  = a_rdata_q;
   assign bus.b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a cycle-level model of the grant rules and memory contents.
module tb_dmem_arbiter;
   localparam int unsigned ADDR_W   = 16;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned MAX_WAIT = 4;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   failures;

   logic [DATA_W-1:0] mem [0:65535];
   logic [DATA_W-1:0] shadow [0:7];

   dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port memory: combinational read, write on rising edge.
   assign bus.mem_read_data = mem[bus.mem_access_addr];
   always @(posedge clk) if (bus.mem_write_en) mem[bus.mem_access_addr] <= bus.mem_write_data;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_idle();
      bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
      bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      bus.a_req = 1; bus.a_we = 1; bus.a_addr = 16'h0020; bus.a_wdata = 16'hAAAA;
      bus.b_req = 1; bus.b_we = 1; bus.b_addr = 16'h0030; bus.b_wdata = 16'hBBBB;
      repeat (2) @(negedge clk);
      tests_run++; if (bus.a_gnt !== 1'b0) begin failures++; $display("FAIL reset_a_gnt: got %b want 0", bus.a_gnt); end
      tests_run++; if (bus.b_gnt !== 1'b0) begin failures++; $display("FAIL reset_b_gnt: got %b want 0", bus.b_gnt); end
      tests_run++; if (bus.a_rvalid !== 1'b0 || bus.b_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %b%b want 00", bus.a_rvalid, bus.b_rvalid); end
      tests_run++; if (bus.a_rdata !== 16'h0 || bus.b_rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata: got %h/%h want 0/0", bus.a_rdata, bus.b_rdata); end
      tests_run++; if (bus.mem_write_en !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_write_en); end
      // Switch both to reads of untouched address 0 before leaving reset.
      bus.a_we = 0; bus.b_we = 0; bus.a_addr = '0; bus.b_addr = '0;
      rst_n = 1;
      @(posedge clk); #1;
      tests_run++; if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin failures++; $display("FAIL reset_first_contend: got a=%b b=%b want a=1 b=0", bus.a_gnt, bus.b_gnt); end
      @(negedge clk);
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_write_read();
      bus.a_req = 1; bus.a_we = 1; bus.a_addr = 16'h0010; bus.a_wdata = 16'hBEEF;
      #1;
      tests_run++; if (bus.a_gnt !== 1'b1 || bus.mem_write_en !== 1'b1 || bus.mem_access_addr !== 16'h0010 || bus.mem_write_data !== 16'hBEEF)
         begin failures++; $display("FAIL wr_cycle: got gnt=%b we=%b addr=%h data=%h want 1 1 0010 beef", bus.a_gnt, bus.mem_write_en, bus.mem_access_addr, bus.mem_write_data); end
      @(negedge clk);
      bus.a_we = 0;
      #1;
      tests_run++; if (bus.a_gnt !== 1'b1 || bus.mem_read !== 1'b1 || bus.mem_write_en !== 1'b0)
         begin failures++; $display("FAIL rd_cycle: got gnt=%b rd=%b we=%b want 1 1 0", bus.a_gnt, bus.mem_read, bus.mem_write_en); end
      @(negedge clk);
      bus.a_req = 0;
      tests_run++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 16'hBEEF)
         begin failures++; $display("FAIL wr_rd_data: got rvalid=%b rdata=%h want 1 beef", bus.a_rvalid, bus.a_rdata); end
      tests_run++; if (bus.b_rvalid !== 1'b0) begin failures++; $display("FAIL wr_rd_b_rvalid: got %b want 0", bus.b_rvalid); end
      @(negedge clk);
      tests_run++; if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 16'hBEEF)
         begin failures++; $display("FAIL wr_rd_hold: got rvalid=%b rdata=%h want 0 beef", bus.a_rvalid, bus.a_rdata); end
   endtask

   task automatic test_contention();
      bus.a_req = 1; bus.a_we = 0; bus.a_addr = 16'h0040;
      bus.b_req = 1; bus.b_we = 0; bus.b_addr = 16'h0050;
      for (int i = 0; i < 3 * (MAX_WAIT + 1); i++) begin
         logic exp_b;
         exp_b = ((i % (MAX_WAIT + 1)) == MAX_WAIT);
         #1;
         tests_run++; if (bus.a_gnt !== !exp_b || bus.b_gnt !== exp_b)
            begin failures++; $display("FAIL contend_cycle%0d: got a=%b b=%b want a=%b b=%b", i, bus.a_gnt, bus.b_gnt, !exp_b, exp_b); end
         @(negedge clk);
      end
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_b_alone();
      mem[16'h1FFF] = 16'h1234;
      bus.b_req = 1; bus.b_we = 0; bus.b_addr = 16'h1FFF;
      #1;
      tests_run++; if (bus.b_gnt !== 1'b1 || bus.a_gnt !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_access_addr !== 16'h1FFF)
         begin failures++; $display("FAIL b_alone_gnt: got b=%b a=%b rd=%b addr=%h want 1 0 1 1fff", bus.b_gnt, bus.a_gnt, bus.mem_read, bus.mem_access_addr); end
      @(negedge clk);
      bus.b_req = 0;
      tests_run++; if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 16'h1234 || bus.a_rvalid !== 1'b0)
         begin failures++; $display("FAIL b_alone_data: got rvalid=%b rdata=%h a_rvalid=%b want 1 1234 0", bus.b_rvalid, bus.b_rdata, bus.a_rvalid); end
      @(negedge clk);
      tests_run++; if (bus.b_rvalid !== 1'b0 || bus.b_rdata !== 16'h1234)
         begin failures++; $display("FAIL b_alone_hold: got rvalid=%b rdata=%h want 0 1234", bus.b_rvalid, bus.b_rdata); end
   endtask

   task automatic test_b_drop();
      bus.a_req = 1; bus.a_we = 0; bus.a_addr = 16'h0060;
      bus.b_req = 1; bus.b_we = 0; bus.b_addr = 16'h0070;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++; if (bus.b_gnt !== 1'b0 || bus.a_gnt !== 1'b1)
            begin failures++; $display("FAIL b_drop_lose%0d: got a=%b b=%b want a=1 b=0", i, bus.a_gnt, bus.b_gnt); end
         @(negedge clk);
      end
      bus.b_req = 0;
      @(negedge clk);
      bus.b_req = 1;
      for (int i = 0; i <= MAX_WAIT; i++) begin
         logic exp_b;
         exp_b = (i == MAX_WAIT);
         #1;
         tests_run++; if (bus.b_gnt !== exp_b || bus.a_gnt !== !exp_b)
            begin failures++; $display("FAIL b_drop_rereq%0d: got a=%b b=%b want a=%b b=%b", i, bus.a_gnt, bus.b_gnt, !exp_b, exp_b); end
         @(negedge clk);
      end
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_random();
      logic pa, pb, ga, gb;
      logic exp_a_rv, exp_b_rv;
      logic [DATA_W-1:0] exp_a_rd, exp_b_rd, exp_wd;
      logic [ADDR_W-1:0] exp_addr;
      int lost;
      // Restart from a clean reset so the model knows every register.
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      for (int k = 0; k < 8; k++) shadow[k] = mem[16'h0100 + 16'(k)];
      pa = 0; pb = 0; lost = 0;
      exp_a_rv = 0; exp_b_rv = 0; exp_a_rd = '0; exp_b_rd = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         tests_run++; if (bus.a_rvalid !== exp_a_rv || bus.a_rdata !== exp_a_rd)
            begin failures++; $display("FAIL rand_a_resp c%0d: got %b/%h want %b/%h", cyc, bus.a_rvalid, bus.a_rdata, exp_a_rv, exp_a_rd); end
         tests_run++; if (bus.b_rvalid !== exp_b_rv || bus.b_rdata !== exp_b_rd)
            begin failures++; $display("FAIL rand_b_resp c%0d: got %b/%h want %b/%h", cyc, bus.b_rvalid, bus.b_rdata, exp_b_rv, exp_b_rd); end
         if (!pa && $urandom_range(0, 3) != 0) begin
            pa = 1; bus.a_we = 1'($urandom_range(0, 1));
            bus.a_addr = 16'h0100 + 16'($urandom_range(0, 7)); bus.a_wdata = 16'($urandom);
         end
         if (!pb && $urandom_range(0, 2) != 0) begin
            pb = 1; bus.b_we = 1'($urandom_range(0, 1));
            bus.b_addr = 16'h0100 + 16'($urandom_range(0, 7)); bus.b_wdata = 16'($urandom);
         end
         bus.a_req = pa; bus.b_req = pb;
         #1;
         // B wins a contended cycle only after losing MAX_WAIT in a row.
         gb = pb && (!pa || lost >= int'(MAX_WAIT));
         ga = pa && !gb;
         exp_addr = ga ? bus.a_addr : (gb ? bus.b_addr : '0);
         exp_wd   = ga ? bus.a_wdata : (gb ? bus.b_wdata : '0);
         tests_run++; if (bus.a_gnt !== ga || bus.b_gnt !== gb)
            begin failures++; $display("FAIL rand_gnt c%0d: got a=%b b=%b want a=%b b=%b", cyc, bus.a_gnt, bus.b_gnt, ga, gb); end
         tests_run++; if (bus.mem_access_addr !== exp_addr || bus.mem_write_data !== exp_wd ||
                          bus.mem_write_en !== ((ga && bus.a_we) || (gb && bus.b_we)) ||
                          bus.mem_read !== ((ga && !bus.a_we) || (gb && !bus.b_we)))
            begin failures++; $display("FAIL rand_mem c%0d: got addr=%h wd=%h we=%b rd=%b want addr=%h wd=%h", cyc, bus.mem_access_addr, bus.mem_write_data, bus.mem_write_en, bus.mem_read, exp_addr, exp_wd); end
         exp_a_rv = ga && !bus.a_we;
         exp_b_rv = gb && !bus.b_we;
         if (exp_a_rv) exp_a_rd = shadow[bus.a_addr[2:0]];
         if (exp_b_rv) exp_b_rd = shadow[bus.b_addr[2:0]];
         if (ga && bus.a_we) shadow[bus.a_addr[2:0]] = bus.a_wdata;
         if (gb && bus.b_we) shadow[bus.b_addr[2:0]] = bus.b_wdata;
         lost = (pb && !gb) ? lost + 1 : 0;
         if (ga) pa = 0;
         if (gb) pb = 0;
      end
      @(negedge clk);
      drive_idle();
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bus.a_req = 1; bus.a_we = 0; bus.a_addr = 16'h0010;
      #1;
      tests_run++; if (bus.a_gnt !== 1'b1) begin failures++; $display("FAIL mid_rst_gnt: got %b want 1", bus.a_gnt); end
      #2;
      rst_n = 0;
      #1;
      tests_run++; if (bus.a_gnt !== 1'b0 || bus.mem_read !== 1'b0)
         begin failures++; $display("FAIL mid_rst_gnt_low: got gnt=%b rd=%b want 0 0", bus.a_gnt, bus.mem_read); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++; if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 16'h0)
            begin failures++; $display("FAIL mid_rst_resp%0d: got rvalid=%b rdata=%h want 0 0000", i, bus.a_rvalid, bus.a_rdata); end
      end
      bus.a_req = 0;
      rst_n = 1;
      @(negedge clk);
      tests_run++; if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 16'h0)
         begin failures++; $display("FAIL mid_rst_after: got rvalid=%b rdata=%h want 0 0000", bus.a_rvalid, bus.a_rdata); end
   endtask

   initial begin
      tests_run = 0;
      failures  = 0;
      for (int k = 0; k < 65536; k++) mem[k] = '0;
      rst_n = 0;
      drive_idle();
      @(negedge clk);
      test_reset();
      test_write_read();
      test_contention();
      test_b_alone();
      test_b_drop();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
